// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 int8 systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int ACC_W          = 16;
    localparam int NBYTES_IN      = 8;
    localparam int COMPUTE_CYCLES = 4;

    localparam logic [1:0] SEL_C00 = 2'b00;
    localparam logic [1:0] SEL_C01 = 2'b01;
    localparam logic [1:0] SEL_C10 = 2'b10;
    localparam logic [1:0] SEL_C11 = 2'b11;
    localparam logic       SEL_LO  = 1'b0;
    localparam logic       SEL_HI  = 1'b1;

    function automatic logic [7:0] sel_byte(
        input logic [ACC_W-1:0] word,
        input logic             hi
    );
        return (hi == SEL_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/systolic_mac2x2_pe.sv
// One output-stationary MAC cell: passes a right, b down, accumulates a*b.
// SYSTOLIC_SATURATE_EN selects clamping instead of two's-complement wrap.
import systolic_pkg::*;

module systolic_pe (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    output logic [7:0]       a_out,
    output logic [7:0]       b_out,
    output logic [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] prod;
    logic        [ACC_W-1:0] acc_next;

    assign prod = 16'($signed(a_in)) * 16'($signed(b_in));

`ifdef SYSTOLIC_SATURATE_EN
    logic signed [ACC_W:0] sum;
    assign sum = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1])
            acc_next = sum[ACC_W] ? 16'h8000 : 16'h7FFF;
    end
`else
    assign acc_next = acc + prod;
`endif

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/systolic_mac2x2.sv
// 2x2 int8 systolic matrix multiplier C = A x B fed one byte at a time.
// Optional SYSTOLIC_SATURATE_EN clamps accumulators instead of wrapping.
import systolic_pkg::*;

module systolic_mac2x2 #(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       save,
    input  logic [2:0] out_sel,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    state_t state, state_next;

    logic [2:0] cnt;
    logic [1:0] cc;
    logic [7:0] ops [NBYTES_IN];
    logic       accept;
    logic       start;
    logic       feed_on;

    logic [7:0] a_feed0, a_raw1, a_skew;
    logic [7:0] b_feed0, b_raw1, b_skew;
    logic [7:0] a00, a10, b00, b01;
    logic [7:0] a01_unused, a11_unused, b10_unused, b11_unused;
    logic [ACC_W-1:0] c00, c01, c10, c11;
    logic [ACC_W-1:0] word;
    logic [7:0]       sel;

    assign accept = save && (state != COMPUTE);
    assign start  = accept && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (save) state_next = LOAD;
            LOAD:    if (save && cnt == 3'(NBYTES_IN - 1)) state_next = COMPUTE;
            COMPUTE: if (cc == 2'(COMPUTE_CYCLES - 1)) state_next = DONE;
            DONE:    if (save) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == LOAD) || (state == COMPUTE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            cc  <= '0;
            for (int i = 0; i < NBYTES_IN; i++) ops[i] <= '0;
        end else begin
            if (accept) begin
                ops[start ? 3'd0 : cnt] <= data_in;
                cnt <= start ? 3'd1 : cnt + 3'd1;
            end
            if (state == COMPUTE) cc <= cc + 2'd1;
        end
    end

    // Only compute steps 0 and 1 carry operands; later steps flush zeros.
    assign feed_on = (state == COMPUTE) && !cc[1];
    assign a_feed0 = feed_on ? ops[{2'b00, cc[0]}] : '0;
    assign a_raw1  = feed_on ? ops[{2'b01, cc[0]}] : '0;
    assign b_feed0 = feed_on ? ops[{1'b1, cc[0], 1'b0}] : '0;
    assign b_raw1  = feed_on ? ops[{1'b1, cc[0], 1'b1}] : '0;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            a_skew <= '0;
            b_skew <= '0;
        end else begin
            a_skew <= a_raw1;
            b_skew <= b_raw1;
        end
    end

    systolic_pe u_pe00 (
        .clk(clk), .reset(reset), .clr(start), .en(state == COMPUTE),
        .a_in(a_feed0), .b_in(b_feed0),
        .a_out(a00), .b_out(b00), .acc(c00)
    );

    systolic_pe u_pe01 (
        .clk(clk), .reset(reset), .clr(start), .en(state == COMPUTE),
        .a_in(a00), .b_in(b_skew),
        .a_out(a01_unused), .b_out(b01), .acc(c01)
    );

    systolic_pe u_pe10 (
        .clk(clk), .reset(reset), .clr(start), .en(state == COMPUTE),
        .a_in(a_skew), .b_in(b00),
        .a_out(a10), .b_out(b10_unused), .acc(c10)
    );

    systolic_pe u_pe11 (
        .clk(clk), .reset(reset), .clr(start), .en(state == COMPUTE),
        .a_in(a10), .b_in(b01),
        .a_out(a11_unused), .b_out(b11_unused), .acc(c11)
    );

    always_comb begin
        word = '0;
        unique case (out_sel[2:1])
            SEL_C00: word = c00;
            SEL_C01: word = c01;
            SEL_C10: word = c10;
            SEL_C11: word = c11;
            default: word = '0;
        endcase
        sel = sel_byte(word, out_sel[0]);
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [7:0] data_q;
            always_ff @(posedge clk) begin
                if (reset) data_q <= '0;
                else       data_q <= sel;
            end
            assign data_out = data_q;
        end else begin : g_ocomb
            assign data_out = sel;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_mac2x2.sv
// Directed bench for systolic_mac2x2; registered and combinational read
// ports are run side by side from the same stimulus.
module tb_systolic_mac2x2;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       save;
    logic [2:0] out_sel;
    logic [7:0] dout_r, dout_c;
    logic       busy_r, done_r, busy_c, done_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] job [8];

    systolic_mac2x2 #(.OUT_REG(1)) u_reg (
        .clk(clk), .reset(reset), .data_in(data_in), .save(save),
        .out_sel(out_sel), .data_out(dout_r), .busy(busy_r), .done(done_r)
    );

    systolic_mac2x2 #(.OUT_REG(0)) u_comb (
        .clk(clk), .reset(reset), .data_in(data_in), .save(save),
        .out_sel(out_sel), .data_out(dout_c), .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_in = b;
        save    = 1'b1;
        tick();
        save    = 1'b0;
    endtask

    // After the 8th accepted byte: 4 COMPUTE cycles, then DONE.
    task automatic finish_job(input string tag);
        check({tag, " busy@e8"}, {15'd0, busy_r}, 16'd1);
        tick(); tick(); tick();
        check({tag, " busy@e8+3"}, {15'd0, busy_r}, 16'd1);
        check({tag, " done@e8+3"}, {15'd0, done_r}, 16'd0);
        tick();
        check({tag, " done@e8+4"}, {15'd0, done_r}, 16'd1);
        check({tag, " busy@e8+4"}, {15'd0, busy_r}, 16'd0);
    endtask

    task automatic run_job(input string tag, input logic [7:0] v [8]);
        for (int i = 0; i < 8; i++) send(v[i]);
        finish_job(tag);
    endtask

    task automatic read_word(input logic [1:0] idx, output logic [15:0] wr,
                             output logic [15:0] wc);
        out_sel = {idx, 1'b0};
        #1 wc[7:0] = dout_c;
        tick();
        wr[7:0] = dout_r;
        out_sel = {idx, 1'b1};
        #1 wc[15:8] = dout_c;
        tick();
        wr[15:8] = dout_r;
    endtask

    task automatic check_mat(input string tag, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3);
        logic [15:0] exp [4];
        logic [15:0] wr, wc;
        exp = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            read_word(2'(k), wr, wc);
            check($sformatf("%s C%0d reg", tag, k), wr, exp[k]);
            check($sformatf("%s C%0d comb", tag, k), wc, exp[k]);
        end
    endtask

    initial begin
        reset   = 1'b1;
        save    = 1'b0;
        data_in = '0;
        out_sel = '0;
        tick();
        tick();
        check("rst dout_r", {8'd0, dout_r}, 16'd0);
        check("rst dout_c", {8'd0, dout_c}, 16'd0);
        check("rst busy", {15'd0, busy_r}, 16'd0);
        check("rst done", {15'd0, done_r}, 16'd0);
        reset = 1'b0;

        // Identity times B, then byte-by-byte readout.
        job = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
        run_job("ident", job);
        begin
            logic [7:0] eb [8];
            eb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
            for (int s = 0; s < 8; s++) begin
                out_sel = 3'(s);
                #1 check($sformatf("ident byte%0d comb", s), {8'd0, dout_c},
                         {8'd0, eb[s]});
                tick();
                check($sformatf("ident byte%0d reg", s), {8'd0, dout_r},
                      {8'd0, eb[s]});
            end
        end

        // Same-cycle vs one-edge-later read port.
        out_sel = 3'b000;
        tick();
        out_sel = 3'b110;
        #1;
        check("oreg comb now", {8'd0, dout_c}, 16'h0004);
        check("oreg reg old", {8'd0, dout_r}, 16'h0001);
        tick();
        check("oreg reg next", {8'd0, dout_r}, 16'h0004);

        // Signed operands; job started straight from DONE.
        job = '{8'hFF, 8'h02, 8'h03, 8'hFC, 8'h05, 8'h06, 8'h07, 8'h08};
        run_job("signed", job);
        check_mat("signed", 16'h0009, 16'h000A, 16'hFFF3, 16'hFFF2);

        // Corner case: (-128)*(-128) summed twice overflows.
        job = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run_job("sat", job);
`ifdef SYSTOLIC_SATURATE_EN
        check_mat("sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
`else
        check_mat("sat", 16'h8000, 16'h8000, 16'h8000, 16'h8000);
`endif

        // Abort after 5 bytes; reset wins over a simultaneous save.
        for (int i = 0; i < 5; i++) send(8'h09);
        check("abort busy pre", {15'd0, busy_r}, 16'd1);
        reset   = 1'b1;
        save    = 1'b1;
        data_in = 8'h33;
        tick();
        reset = 1'b0;
        save  = 1'b0;
        check("abort busy", {15'd0, busy_r}, 16'd0);
        check("abort done", {15'd0, done_r}, 16'd0);
        check("abort dout", {8'd0, dout_r}, 16'd0);
        job = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4};
        run_job("fresh", job);
        check_mat("fresh", 16'd2, 16'd4, 16'd6, 16'd8);

        // Saves held during COMPUTE must be ignored.
        job = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
        for (int i = 0; i < 8; i++) send(job[i]);
        check("ign busy@e8", {15'd0, busy_r}, 16'd1);
        data_in = 8'h7F;
        save    = 1'b1;
        tick(); tick(); tick();
        save = 1'b0;
        check("ign busy@e8+3", {15'd0, busy_r}, 16'd1);
        tick();
        check("ign done", {15'd0, done_r}, 16'd1);
        check_mat("ign", 16'd4, 16'd6, 16'd4, 16'd6);

        // Save in DONE opens a new job with A00 = 2.
        send(8'h02);
        check("restart busy", {15'd0, busy_r}, 16'd1);
        check("restart done", {15'd0, done_r}, 16'd0);
        send(8'd0);
        send(8'd0);
        send(8'd1);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        finish_job("restart");
        check_mat("restart", 16'd2, 16'd4, 16'd3, 16'd4);

        check("comb busy", {15'd0, busy_c}, {15'd0, busy_r});
        check("comb done", {15'd0, done_c}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
